// File: rtl/lut_decoder_pipe.sv
// Registered, run-time programmable lookup decoder with a valid/ready output stage and a sticky write lock.
// Optional per-entry parity (y_par, par_err) is enabled by defining LUT_DECODER_PARITY_EN.
module lut_decoder_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 4,
  parameter logic [OUT_W*(2**IN_W)-1:0] INIT = 32'h20D9C7A4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             lock,
  output logic             locked,
`ifdef LUT_DECODER_PARITY_EN
  output logic             y_par,
  output logic             par_err,
`endif
  output logic             wr_err
);

  localparam int DEPTH = 1 << IN_W;

  logic [OUT_W-1:0] lut_q [DEPTH];
  logic [OUT_W-1:0] rd_data;
  logic [OUT_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             locked_q, locked_d;
  logic             wr_err_q, wr_err_d;
  logic             accept;
  logic             lut_we;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign rd_data  = lut_q[x];
  assign lut_we   = wr_en && !locked_q;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default is how latches sneak in.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = rd_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    locked_d = locked_q || lock;
    wr_err_d = wr_err_q || (wr_en && locked_q);
  end

  // NOTE: the table is a small flop array, so the async reset reloads every
  // entry from INIT; a RAM macro could not do this and would need an init FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= INIT[i*OUT_W +: OUT_W];
    end else if (lut_we) begin
      lut_q[wr_addr] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments keep read-before-write: a lookup and a
  // write to the same entry on one edge both see the pre-edge table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      locked_q    <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      locked_q    <= locked_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign locked    = locked_q;
  assign wr_err    = wr_err_q;

`ifdef LUT_DECODER_PARITY_EN
  logic lut_par_q [DEPTH];
  logic y_par_q, y_par_d;
  logic par_err_q, par_err_d;

  always_comb begin
    y_par_d   = accept ? ^rd_data : y_par_q;
    par_err_d = par_err_q || (accept && (lut_par_q[x] != ^rd_data));
  end

  // Stored parity is taken from the incoming word at load/write time, so a
  // corrupted data bit shows up as a mismatch on the next lookup of that entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) lut_par_q[i] <= ^INIT[i*OUT_W +: OUT_W];
    end else if (lut_we) begin
      lut_par_q[wr_addr] <= ^wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par_q   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      y_par_q   <= y_par_d;
      par_err_q <= par_err_d;
    end
  end

  assign y_par   = y_par_q;
  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_lut_decoder_pipe.sv
// Scoreboard bench for lut_decoder_pipe: a cycle driver feeds a table model and
// pushes expected words; an independent monitor pops them on each output transfer.
module tb_lut_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] x = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] y;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       lock = 1'b0;
  logic       locked;
  logic       wr_err;
`ifdef LUT_DECODER_PARITY_EN
  logic       y_par;
  logic       par_err;
`endif

  lut_decoder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lock      (lock),
    .locked    (locked),
`ifdef LUT_DECODER_PARITY_EN
    .y_par     (y_par),
    .par_err   (par_err),
`endif
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the decode table as documented, plus lock/error/valid state.
  logic [3:0] model [8];
  logic       m_locked, m_wrerr, m_ov;
  logic [3:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model    = '{4'h4, 4'hA, 4'h7, 4'hC, 4'h9, 4'hD, 4'h0, 4'h2};
    m_locked = 1'b0;
    m_wrerr  = 1'b0;
    m_ov     = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle of stimulus; the model predicts what the next edge does.
  task automatic step(input logic iv, input logic [2:0] xi, input logic ordy,
                      input logic we, input logic [2:0] wa, input logic [3:0] wd,
                      input logic lk);
    logic exp_rdy, acc;
    @(posedge clk);
    #2;
    check("out_valid", out_valid, m_ov);
    check("locked", locked, m_locked);
    check("wr_err", wr_err, m_wrerr);
`ifdef LUT_DECODER_PARITY_EN
    check("par_err", par_err, 0);
`endif
    in_valid = iv; x = xi; out_ready = ordy;
    wr_en = we; wr_addr = wa; wr_data = wd; lock = lk;
    #1;
    exp_rdy = !m_ov || ordy;
    check("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy;
    if (acc) exp_q.push_back(model[xi]);
    if (we) begin
      if (m_locked) m_wrerr = 1'b1;
      else          model[wa] = wd;
    end
    if (lk) m_locked = 1'b1;
    if (acc)       m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
  endtask

  // Monitor: a transfer happens at the coming edge whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=%0h expected=none at %0t", y, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("y", y, e);
`ifdef LUT_DECODER_PARITY_EN
        check("y_par", y_par, ^e);
`endif
      end
    end
  end

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_locked", locked, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_in_ready", in_ready, 1);

    // Reset defaults, back to back.
    for (int i = 0; i < 8; i++) step(1, 3'(i), 1, 0, 0, 0, 0);

    // Stall: x=3 held for 3 cycles while x=5 waits, then drains.
    step(1, 3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // Write collision: same-cycle lookup sees the old entry.
    step(1, 2, 1, 1, 2, 4'hF, 0);
    step(1, 2, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // Randomised traffic before locking.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1), 3'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), 3'($urandom), 4'($urandom), 1'b0);
    step(0, 0, 1, 0, 0, 0, 0);

    // Lock: write in the same cycle as the first lock pulse still lands.
    step(0, 0, 1, 1, 1, 4'h0, 1);
    step(0, 0, 1, 1, 1, 4'h5, 0);
    step(1, 1, 1, 0, 0, 0, 0);

    // Randomised traffic after locking; writes must all be refused.
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1), 3'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), 3'($urandom), 4'($urandom),
           ($urandom_range(0, 15) == 0));

    // Async reset mid-stall.
    step(1, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #4;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_locked", locked, 0);
    model_reset();
    in_valid = 1'b0; wr_en = 1'b0; lock = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1, 2, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_decoder_pipe.md
Name: lut_decoder_pipe

Overview:
- Parametrised, registered lookup decoder: maps an IN_W-bit code x to an OUT_W-bit word y through a table of 2**IN_W entries.
- The table is reprogrammable at run time and can be locked against further writes.
- Lookups use a valid/ready handshake with a one-entry output register, so the block drops into streaming datapaths in place of a fixed combinational decoder.

Parameters:
- IN_W, 3, input code width; table depth is 2**IN_W.
- OUT_W, 4, output word width.
- INIT, 32'h20D9C7A4, flat table reset image of OUT_W*2**IN_W bits; entry i is INIT[i*OUT_W +: OUT_W]. The default gives 0:0100 1:1010 2:0111 3:1100 4:1001 5:1101 6:0000 7:0010.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  block can accept a request this cycle.
- x  in  IN_W  code to decode.
- out_valid  out  1  y holds a valid result.
- out_ready  in  1  downstream accepts y.
- y  out  OUT_W  decoded word (registered).
- wr_en  in  1  table write strobe.
- wr_addr  in  IN_W  table entry to write.
- wr_data  in  OUT_W  new entry value.
- lock  in  1  pulse high sets the sticky lock; further writes are refused.
- locked  out  1  lock state.
- wr_err  out  1  sticky flag: a write was attempted while locked.

Behaviour:
- Reset (asynchronous, rst_n=0): table is loaded from INIT; out_valid=0, y=0, locked=0, wr_err=0. in_ready=1 as soon as reset is released.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A request is accepted when in_valid && in_ready.
  - On acceptance: y <= table[x] and out_valid <= 1 on the next edge. Latency is 1 cycle.
  - If out_valid && out_ready and no new request is accepted, out_valid <= 0 and y holds its last value.
  - If out_valid && !out_ready, y and out_valid hold (stall) and in_ready=0.
  - Back-to-back throughput is 1 lookup/cycle while out_ready=1.
- Table write:
  - If wr_en && !locked, table[wr_addr] <= wr_data at the edge.
  - If wr_en && locked, the table is unchanged and wr_err <= 1. wr_err is sticky until reset.
- Simultaneous lookup and write to the same address in one cycle: the lookup returns the OLD entry (read-before-write). The new value is visible to lookups accepted on the next cycle onward.
- Lock:
  - lock=1 at an edge sets locked <= 1. Only reset clears it.
  - wr_en together with the first lock pulse: the write is still performed, because the write sees the pre-edge locked=0. No error is flagged.
- A result already in the output register is never altered by later table writes.
- in_valid=0 with in_ready=1: no state change except writes and lock.
- Reset mid-stall discards the pending result (out_valid=0) and reloads the table from INIT.
- Widths: no arithmetic; x indexes all 2**IN_W entries, so no out-of-range case exists.

Optional Feature:
- Macro: LUT_DECODER_PARITY_EN.
- Defined:
  - Adds output port y_par (1 bit), the registered even parity (XOR reduction) of y.
  - y_par updates and holds together with y; its reset value is 0.
  - Adds a parity bit to each table entry, computed at write time and at reset. On every accepted lookup the stored parity is checked against the parity of the read data. A mismatch sets sticky output par_err (reset value 0).
- Undefined: neither y_par nor par_err exists, and the table stores only OUT_W bits per entry.

Test Plan:
- Reset defaults: release reset; hold out_ready=1; send x=0..7 back to back -> y=4'h4,4'hA,4'h7,4'hC,4'h9,4'hD,4'h0,4'h2, each 1 cycle after acceptance; out_valid high for 8 consecutive cycles.
- Stall: send x=3; out_ready=0 for 3 cycles -> y=4'hC held, out_valid=1, in_ready=0; then out_ready=1 -> transfer completes and the next x=5 gives y=4'hD.
- Write collision: in one cycle, wr_en=1, wr_addr=2, wr_data=4'hF and lookup x=2 -> y=4'h7; lookup x=2 on the next cycle -> y=4'hF.
- Lock: pulse lock with wr_en=1, wr_addr=1, wr_data=4'h0 -> entry 1 becomes 0, wr_err=0, locked=1. Then write addr 1 to 4'h5 -> wr_err=1 and lookup x=1 still returns 4'h0.
- Async reset mid-stall: with out_valid=1 and out_ready=0, assert rst_n=0 between clock edges -> out_valid=0, y=0 immediately. After release, x=2 returns 4'h7 (INIT restored) and locked=0.
- Parity (macro defined): lookup x=1 -> y=4'hA, y_par=0; lookup x=5 -> y=4'hD, y_par=1; par_err remains 0.
